// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a program into instruction memory from a byte stream.
// Bytes arrive over valid/ready and are packed little-endian into 32-bit words.
// Each word is written at consecutive word addresses starting from 0. cpu_hold
// keeps the pipeline frozen while the load runs. A done pulse, with error,
// reports how the load ended.
// Optional feature: define CHECKSUM_EN to expect one trailing byte after the
// last word. That byte must equal the 8-bit sum (mod 256) of all program bytes.
module inst_mem_loader #(
  parameter int MEM_BYTES = 88,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [63:0]      wr_address,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
`ifdef CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd4;
`endif

  // Largest word count that still fits in the instruction memory.
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / 4);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] words_loaded_reg, words_loaded_next;
  logic [CNT_W-1:0] words_inc;
  logic [1:0]       byte_idx_reg, byte_idx_next;
  logic [31:0]      asm_reg, asm_next;
  logic [31:0]      asm_word;
  logic [63:0]      wr_address_reg, wr_address_next;
  logic [31:0]      wr_data_reg, wr_data_next;
  logic             error_reg, error_next;
  logic             accept;
`ifdef CHECKSUM_EN
  logic [7:0]       sum_reg, sum_next;
`endif

  // A byte is taken only in the states that raise byte_ready.
  assign accept    = byte_valid && byte_ready;
  assign words_inc = words_loaded_reg + CNT_W'(1);

  // The incoming byte is merged into its lane. This gives the full word in the
  // same cycle as the fourth byte, so WRITE can follow directly.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_word[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? byte_data : asm_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state and datapath update logic.
  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    words_loaded_next = words_loaded_reg;
    byte_idx_next     = byte_idx_reg;
    asm_next          = asm_reg;
    wr_address_next   = wr_address_reg;
    wr_data_next      = wr_data_reg;
    error_next        = error_reg;
`ifdef CHECKSUM_EN
    sum_next          = sum_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          count_next        = word_count;
          words_loaded_next = '0;
          byte_idx_next     = '0;
          error_next        = 1'b0;
`ifdef CHECKSUM_EN
          sum_next          = '0;
`endif
          if (word_count == '0) begin
            state_next = S_FIN;
          end else if (word_count > MAX_WORDS) begin
            // Oversized program: reject it without touching memory or the CPU.
            error_next = 1'b1;
            state_next = S_FIN;
          end else begin
            state_next = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (accept) begin
          asm_next      = asm_word;
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef CHECKSUM_EN
          sum_next      = sum_reg + byte_data;
`endif
          if (byte_idx_reg == 2'd3) begin
            wr_data_next    = asm_word;
            wr_address_next = 64'(words_loaded_reg) << 2;
            state_next      = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_loaded_next = words_inc;
        if (words_inc == count_reg) begin
`ifdef CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_FIN;
`endif
        end else begin
          state_next = S_RECV;
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        // Words already written stay in memory; a bad sum only flags the load.
        if (accept) begin
          error_next = (byte_data != sum_reg);
          state_next = S_FIN;
        end
      end
`endif
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, including any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      count_reg        <= '0;
      words_loaded_reg <= '0;
      byte_idx_reg     <= '0;
      asm_reg          <= '0;
      wr_address_reg   <= '0;
      wr_data_reg      <= '0;
      error_reg        <= 1'b0;
`ifdef CHECKSUM_EN
      sum_reg          <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      words_loaded_reg <= words_loaded_next;
      byte_idx_reg     <= byte_idx_next;
      asm_reg          <= asm_next;
      wr_address_reg   <= wr_address_next;
      wr_data_reg      <= wr_data_next;
      error_reg        <= error_next;
`ifdef CHECKSUM_EN
      sum_reg          <= sum_next;
`endif
    end
  end

  // Status outputs decode straight from the state. An async reset therefore
  // drops them at once, without waiting for a clock edge.
  always_comb begin
`ifdef CHECKSUM_EN
    byte_ready = (state_reg == S_RECV) || (state_reg == S_CSUM);
    cpu_hold   = (state_reg == S_RECV) || (state_reg == S_WRITE) || (state_reg == S_CSUM);
`else
    byte_ready = (state_reg == S_RECV);
    cpu_hold   = (state_reg == S_RECV) || (state_reg == S_WRITE);
`endif
    wr_en        = (state_reg == S_WRITE);
    done         = (state_reg == S_FIN);
    error        = (state_reg == S_FIN) && error_reg;
    wr_address   = wr_address_reg;
    wr_data      = wr_data_reg;
    words_loaded = words_loaded_reg;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: self-checking bench for inst_mem_loader.
// Expected writes go into a scoreboard queue when a load is started. A negedge
// monitor pops and compares them as wr_en pulses. Table-driven loads run
// first, then hand-written sequences: a full-memory load, a mid-load reset,
// and (when CHECKSUM_EN is defined) checksum pass/fail.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  localparam int MEM_BYTES = 88;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             wr_en;
  logic [63:0]      wr_address;
  logic [31:0]      wr_data;
  logic             cpu_hold;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    int          nsend;
    bit          gap;
    bit          exp_err;
    bit          exp_hold;
    bit          chk_loaded;
    int          exp_loaded;
  } vec_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  bit          hold_seen = 1'b0;
  logic [31:0] prog_words [0:31];
  vec_t        vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on every write, plus done/hold bookkeeping.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1) begin
      if (cpu_hold) hold_seen = 1'b1;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write", wr_address, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_address", wr_address, e.addr);
          check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
          $display("write addr=0x%0h data=0x%08h", wr_address, wr_data);
        end
      end
      if (done) begin
        done_cnt++;
        last_err = error;
      end
    end
  end

  // Offer one byte until accepted, optionally followed by one idle cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      if (byte_ready) ok = 1'b1;
      @(posedge clk);
    end
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
      @(posedge clk);
    end
  endtask

  // Run one load of prog_words[0..nsend-1] and check its outcome.
  task automatic run_load(input string tag, input int cnt, input int nsend, input bit gap,
                          input bit exp_err, input bit exp_hold, input bit chk_loaded,
                          input int exp_loaded, input logic [7:0] csum_delta);
    bit         ok;
    logic [7:0] sum;
    logic [7:0] b;
    int         waitc;
    wr_t        e;
    sum = 8'd0;
    for (int w = 0; w < nsend; w++) begin
      e.addr = 64'(4 * w);
      e.data = prog_words[w];
      exp_q.push_back(e);
    end
    @(negedge clk);
    hold_seen  = 1'b0;
    done_cnt   = 0;
    start      = 1'b1;
    word_count = cnt[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < nsend; w++) begin
      for (int k = 0; k < 4; k++) begin
        b   = prog_words[w][8*k +: 8];
        sum = sum + b;
        send_byte(b, gap, ok);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL %s_byte_accept: got no byte_ready expected acceptance (word %0d byte %0d)", tag, w, k);
        end
      end
    end
`ifdef CHECKSUM_EN
    if (cnt > 0 && cnt <= MEM_BYTES / 4) begin
      send_byte(sum + csum_delta, gap, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s_csum_accept: got no byte_ready expected acceptance", tag);
      end
    end
`else
    if (csum_delta != 8'd0) sum = sum + csum_delta;
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    waitc = 0;
    while (done_cnt == 0 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_error"}, {63'd0, last_err}, {63'd0, exp_err});
    check({tag, "_hold_after"}, {63'd0, cpu_hold}, 64'd0);
    check({tag, "_hold_seen"}, {63'd0, hold_seen}, {63'd0, exp_hold});
    if (chk_loaded) check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_loaded));
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("load %s: count=%0d done=%0d error=%0b words_loaded=%0d", tag, cnt, done_cnt, last_err, words_loaded);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    vecs[0] = '{"two_words",     2,  32'h00000913, 32'h00000433, 2, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[1] = '{"two_words_gap", 2,  32'h00000913, 32'h00000433, 2, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    vecs[2] = '{"zero_count",    0,  32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{"overflow_23",   23, 32'h0,        32'h0,        0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{"one_word",      1,  32'hDEADBEEF, 32'h0,        1, 1'b0, 1'b0, 1'b1, 1'b1, 1};

    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_wr_address", wr_address, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      prog_words[0] = vecs[i].w0;
      prog_words[1] = vecs[i].w1;
      run_load(vecs[i].name, vecs[i].cnt, vecs[i].nsend, vecs[i].gap, vecs[i].exp_err,
               vecs[i].exp_hold, vecs[i].chk_loaded, vecs[i].exp_loaded, 8'd0);
    end

    // Fill the whole memory: 22 words, last write lands at byte address 84.
    for (int w = 0; w < 22; w++) prog_words[w] = $urandom;
    run_load("full_22", 22, 22, 1'b0, 1'b0, 1'b1, 1'b1, 22, 8'd0);
    check("full_22_last_address", wr_address, 64'd84);

    // Reset in the middle of a word, then reload; stale bytes must not leak.
    @(negedge clk);
    start      = 1'b1;
    word_count = 16'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hAA, 1'b0, ok);
    send_byte(8'hBB, 1'b0, ok);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("midrst_wr_en", {63'd0, wr_en}, 64'd0);
    check("midrst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_error", {63'd0, error}, 64'd0);
    check("midrst_wr_address", wr_address, 64'd0);
    check("midrst_wr_data", {32'd0, wr_data}, 64'd0);
    check("midrst_words_loaded", 64'(words_loaded), 64'd0);
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prog_words[0] = 32'hFA000AE3;
    run_load("reset_reload", 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'd0);

`ifdef CHECKSUM_EN
    // Correct trailing sum 0x1C, then a wrong one 0x1D; the word is written either way.
    prog_words[0] = 32'h00000913;
    run_load("csum_ok", 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 8'd0);
    run_load("csum_bad", 1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
